// File: rtl/moving_sum_window_pkg.sv
// Defaults and helpers for the runtime-configurable moving-sum filter.
package moving_sum_window_pkg;
`include "dsp_consts.vh"

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_MAX_LEN = 32;
  localparam int DEF_LEN_W   = 6;
  localparam int DEF_ACC_W   = `DSP_ACC_W(DEF_WIDTH, DEF_MAX_LEN);

  // A zero length still means "pass the sample through", hence the floor of 1.
  function automatic int clamp_len(input int len, input int max_len);
    if (len == 0) begin
      return 1;
    end else if (len > max_len) begin
      return max_len;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/dsp_consts.vh
// Shared DSP sizing macros: ceil-log2 and the accumulator growth rule for
// integrators that sum up to N samples of width W.
`ifndef DSP_CONSTS_VH
`define DSP_CONSTS_VH

`define DSP_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`define DSP_ACC_W(w, n) ((w) + $clog2(n))

`endif

// File: rtl/moving_sum_window_sample_ring.sv
// Circular sample store: one write per enable, wrapping pointer, and a
// combinational read of the sample written `offset` writes ago.
`include "dsp_consts.vh"

module sample_ring #(
  parameter int WIDTH   = 16,
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [LEN_W-1:0] offset,
  output logic [WIDTH-1:0] rd_data
);

  localparam int PTR_W = `DSP_CLOG2(MAX_LEN);
  localparam logic [LEN_W:0] DEPTH = (LEN_W + 1)'(MAX_LEN);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(MAX_LEN - 1);

  logic [PTR_W-1:0] wp;
  logic [WIDTH-1:0] mem [MAX_LEN];
  logic [LEN_W:0]   rd_sum;
  logic [LEN_W:0]   rd_idx;

  // offset ranges 1..MAX_LEN, so one conditional subtract gives the modulo;
  // offset == MAX_LEN reads the slot about to be overwritten, before the write.
  always_comb begin
    rd_sum = (LEN_W + 1)'(wp) + DEPTH - {1'b0, offset};
    rd_idx = rd_sum;
    if (rd_sum >= DEPTH) begin
      rd_idx = rd_sum - DEPTH;
    end
  end

  assign rd_data = mem[PTR_W'(rd_idx)];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wp <= '0;
    end else if (wr_en) begin
      wp <= (wp == LAST) ? '0 : wp + 1'b1;
    end
  end

  // Contents are never cleared; the caller masks stale entries.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wp] <= wr_data;
    end
  end

endmodule

// File: rtl/moving_sum_window.sv
// Boxcar filter y[n] = y[n-1] + x[n] - x[n-L] with run-time L, AXI-stream
// in/out, partial-window flag on o_tuser and automatic flush on length change.
module moving_sum_window
  import moving_sum_window_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int ACC_W   = WIDTH + 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [LEN_W-1:0]        len,
  input  logic signed [WIDTH-1:0] i_tdata,
  input  logic                    i_tvalid,
  output logic                    i_tready,
  output logic signed [ACC_W-1:0] o_tdata,
  output logic                    o_tuser,
  output logic                    o_tvalid,
  input  logic                    o_tready
);

  logic [LEN_W-1:0]        le_c;
  logic [LEN_W-1:0]        le_q;
  logic [LEN_W-1:0]        fc;
  logic [LEN_W-1:0]        fc_n;
  logic                    flush;
  logic                    accept;
  logic                    full;
  logic [WIDTH-1:0]        old_sample;
  logic signed [ACC_W-1:0] sub;
  logic signed [ACC_W-1:0] acc_n;

  assign le_c  = LEN_W'(clamp_len(int'(len), MAX_LEN));
  assign flush = clear || (le_c != le_q);

  // Handshake: a beat moves on either side when valid and ready are both high
  // at a rising edge. The output register can take a new sample whenever it is
  // empty or being drained this cycle; ready is forced low during reset.
  assign i_tready = !reset && (!o_tvalid || o_tready);
  assign accept   = i_tvalid && i_tready;

  sample_ring #(
    .WIDTH  (WIDTH),
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_ring (
    .clk    (clk),
    .reset  (reset),
    .clear  (flush),
    .wr_en  (accept && !flush),
    .wr_data(i_tdata),
    .offset (le_q),
    .rd_data(old_sample)
  );

  // The accumulator lives in o_tdata: both only move on accept or flush.
  always_comb begin
    full = (fc >= le_q);
    sub  = '0;
    fc_n = fc + 1'b1;
    if (full) begin
      sub  = ACC_W'(signed'(old_sample));
      fc_n = le_q;
    end
    acc_n = o_tdata + ACC_W'(i_tdata) - sub;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      le_q     <= le_c;
      fc       <= '0;
      o_tdata  <= '0;
      o_tuser  <= 1'b0;
      o_tvalid <= 1'b0;
    end else begin
      le_q <= le_c;
      if (flush) begin
        fc       <= '0;
        o_tdata  <= '0;
        o_tuser  <= 1'b0;
        o_tvalid <= 1'b0;
      end else if (accept) begin
        fc       <= fc_n;
        o_tdata  <= acc_n;
        o_tuser  <= (fc_n == le_q);
        o_tvalid <= 1'b1;
      end else if (o_tready) begin
        o_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_moving_sum_window.sv
// Directed bench for moving_sum_window: hand-computed sums, output scoreboard
// on every output handshake, plus direct checks of handshake and hold states.
module tb_moving_sum_window;
  localparam int WIDTH   = 16;
  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;
  localparam int ACC_W   = 21;

  logic                    clk;
  logic                    reset;
  logic                    clear;
  logic [LEN_W-1:0]        len;
  logic signed [WIDTH-1:0] i_tdata;
  logic                    i_tvalid;
  logic                    i_tready;
  logic signed [ACC_W-1:0] o_tdata;
  logic                    o_tuser;
  logic                    o_tvalid;
  logic                    o_tready;

  int total = 0;
  int bad   = 0;
  logic [ACC_W:0] exp_q[$];

  moving_sum_window #(
    .WIDTH  (WIDTH),
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .len     (len),
    .i_tdata (i_tdata),
    .i_tvalid(i_tvalid),
    .i_tready(i_tready),
    .o_tdata (o_tdata),
    .o_tuser (o_tuser),
    .o_tvalid(o_tvalid),
    .o_tready(o_tready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [ACC_W:0] mk(input logic user, input int value);
    return {user, ACC_W'(value)};
  endfunction

  // scoreboard: every output handshake must match the next expected beat
  always @(negedge clk) begin
    if (!reset && o_tvalid && o_tready) begin
      if (exp_q.size() == 0) begin
        chk("extra_out", {o_tuser, o_tdata}, '1);
      end else begin
        chk("out", {o_tuser, o_tdata}, exp_q.pop_front());
      end
    end
  end

  // driver tasks: entered and left at posedge + 1
  task automatic send(input int x);
    int n = 0;
    i_tvalid = 1'b1;
    i_tdata  = WIDTH'(x);
    @(negedge clk);
    while (!i_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    i_tvalid = 1'b0;
  endtask

  task automatic set_len(input int v);
    len = LEN_W'(v);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    clear    = 1'b0;
    len      = 6'd4;
    i_tvalid = 1'b0;
    i_tdata  = '0;
    o_tready = 1'b1;

    // reset: 3 cycles
    @(negedge clk);
    chk("rst_itready", i_tready, 0);
    chk("rst_ovalid", o_tvalid, 0);
    chk("rst_odata", o_tdata, 0);
    chk("rst_ouser", o_tuser, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_itready", i_tready, 1);
    @(posedge clk);
    #1;

    // ramp, len=4
    exp_q.push_back(mk(0, 1));  exp_q.push_back(mk(0, 3));
    exp_q.push_back(mk(0, 6));  exp_q.push_back(mk(1, 10));
    exp_q.push_back(mk(1, 14)); exp_q.push_back(mk(1, 18));
    send(1);
    chk("lat_valid", o_tvalid, 1);
    chk("lat_data", o_tdata, 1);
    for (int k = 2; k <= 6; k++) send(k);
    @(posedge clk);
    #1;
    chk("idle_valid", o_tvalid, 0);

    // backpressure, len=3, constant 100
    set_len(3);
    exp_q.push_back(mk(0, 100));
    exp_q.push_back(mk(0, 200));
    for (int k = 0; k < 6; k++) exp_q.push_back(mk(1, 300));
    fork
      begin
        for (int k = 0; k < 8; k++) send(100);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        o_tready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("bp_itready", i_tready, 0);
          chk("bp_ovalid", o_tvalid, 1);
          chk("bp_hold", o_tdata, 300);
        end
        @(posedge clk);
        #1;
        o_tready = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // signed extremes, len=32
    set_len(32);
    for (int k = 1; k <= 40; k++) begin
      exp_q.push_back(mk(k >= 32, -32768 * ((k < 32) ? k : 32)));
      send(-32768);
    end
    chk("neg_settle", o_tdata, -1048576);
    for (int j = 1; j <= 32; j++) begin
      exp_q.push_back(mk(1, -32768 * (32 - j) + 32767 * j));
      send(32767);
    end
    chk("pos_settle", o_tdata, 1048544);
    repeat (2) @(posedge clk);
    #1;

    // length change 4 -> 2 flushes the window
    set_len(4);
    exp_q.push_back(mk(0, 1));  exp_q.push_back(mk(0, 3));
    exp_q.push_back(mk(0, 6));  exp_q.push_back(mk(1, 10));
    exp_q.push_back(mk(1, 14));
    for (int k = 1; k <= 5; k++) send(k);
    repeat (2) @(posedge clk);
    #1;
    set_len(2);
    chk("flush_data", o_tdata, 0);
    chk("flush_user", o_tuser, 0);
    exp_q.push_back(mk(0, 7)); exp_q.push_back(mk(1, 16)); exp_q.push_back(mk(1, 20));
    send(7); send(9); send(11);
    repeat (2) @(posedge clk);
    #1;

    // clamping: len=0 acts as 1, len=63 acts as 32
    set_len(0);
    exp_q.push_back(mk(1, 5)); exp_q.push_back(mk(1, -3)); exp_q.push_back(mk(1, 8));
    send(5); send(-3); send(8);
    repeat (2) @(posedge clk);
    #1;
    set_len(63);
    for (int k = 1; k <= 34; k++) begin
      exp_q.push_back(mk(k >= 32, (k < 32) ? k : 32));
      send(1);
    end
    repeat (2) @(posedge clk);
    #1;

    // clear together with an accept discards the sample
    set_len(3);
    exp_q.push_back(mk(0, 10)); exp_q.push_back(mk(0, 30));
    send(10); send(20);
    clear    = 1'b1;
    i_tvalid = 1'b1;
    i_tdata  = 16'sd99;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    i_tvalid = 1'b0;
    chk("clr_ovalid", o_tvalid, 0);
    chk("clr_odata", o_tdata, 0);
    exp_q.push_back(mk(0, 5));
    send(5);
    chk("clr_next_data", o_tdata, 5);
    chk("clr_next_user", o_tuser, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/moving_sum_window.md
Name: moving_sum_window

Overview:
- Runtime-configurable boxcar (moving-sum) filter: y[n] = y[n-1] + x[n] - x[n-L], with window length L chosen at run time in 1..MAX_LEN.
- Full AXI-stream handshake with a registered output and correct backpressure.
- Partial-window flagging, and automatic flush when L changes.
- Sits in the DSP library ahead of decimators and power/energy detectors.

Parameters:
- WIDTH, 16, signed input sample width.
- MAX_LEN, 32, largest supported window (>=2, need not be a power of two).
- LEN_W, 6, width of the len port; must hold MAX_LEN.
- ACC_W, WIDTH+5, output/accumulator width. Must be >= WIDTH+ceil(log2(MAX_LEN)) so no overflow is possible.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; initialises all state
- clear  in  1  synchronous flush; same effect as reset on datapath state
- len  in  LEN_W  window length, quasi-static setting
- i_tdata  in  WIDTH  signed sample
- i_tvalid  in  1  input valid
- i_tready  out  1  input ready
- o_tdata  out  ACC_W  signed moving sum
- o_tuser  out  1  1 = window full (sum covers exactly L real samples)
- o_tvalid  out  1  output valid
- o_tready  in  1  output ready

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset/clear values: o_tvalid=0, o_tdata=0, o_tuser=0, accumulator=0, write pointer=0, fill count=0.
  - Ring contents are not cleared; stale entries are masked by the fill count (below).
- Length clamping: effective length Le = 1 if len==0; MAX_LEN if len>MAX_LEN; otherwise len.
- Length change: Le is registered every cycle. When the new Le differs from the registered value, an internal flush equal to clear occurs on the next cycle.
  - Any output already held in the output register is dropped.
  - Change len only while idle.
- Handshake:
  - i_tready = ~o_tvalid | o_tready; it is 0 during reset.
  - Accept = i_tvalid & i_tready.
  - o_tvalid is set on accept, held until o_tready, and cleared when o_tready without a new accept.
  - o_tdata/o_tuser are stable while o_tvalid & ~o_tready.
- Latency: 1 cycle, accept to o_tvalid. Full throughput of 1 sample/cycle when o_tready is held high.
- Ring buffer: MAX_LEN x WIDTH register array, write pointer wp wraps MAX_LEN-1 -> 0.
  - Old sample is read at index (wp - Le) mod MAX_LEN, combinationally, before the write in the same cycle.
  - Le==MAX_LEN reads the slot being overwritten, and that read is correct.
- Fill count fc saturates at Le.
  - Subtracted term = ring value if fc==Le, else 0.
  - On accept: acc <= acc + sext(x) - sub; fc <= min(fc+1, Le).
  - o_tuser = (fc after the update == Le).
- Arithmetic: signed, sign-extended to ACC_W, no saturation needed by construction.
- Simultaneous events:
  - reset has priority over clear, and clear over accept.
  - clear and accept in the same cycle: the sample is discarded and o_tvalid=0.

Decomposition:
- Shared constants file `dsp_consts.vh`: macro for ceil-log2 and the default ACC_W growth rule, reused by other integrators.
- One natural sub-module, `sample_ring`:
  - parametrised WIDTH/MAX_LEN circular store with write enable, pointer wrap and offset read port.
  - Top level keeps the handshake, fill count and accumulator.

Test Plan:
- Reset/ramp: reset 3 cycles; len=4, o_tready=1, feed 1,2,3,4,5,6 -> o_tdata 1,3,6,10,14,18; o_tuser 0,0,0,1,1,1; each output 1 cycle after accept.
- Backpressure: len=3, constant input 100; o_tready low for 4 cycles mid-stream -> i_tready low, o_tdata held at 300, no sample lost or duplicated.
- Signed wrap/extremes: WIDTH=16, len=32, feed -32768 x40 -> settles at -1048576 with no overflow; then +32767 x32 -> 1048544.
- Length change: running with len=4, switch to len=2 -> flush; next inputs 7,9,11 -> 7,16,20 with tuser 0,1,1.
- Clamping: len=0 -> output equals input each cycle with tuser=1; len=63 with MAX_LEN=32 -> behaves as len=32.
- Clear mid-stream with simultaneous accept -> o_tvalid=0 next cycle; next sample 5 -> o_tdata=5, tuser=0 (len>1).
